// File: rtl/color_manager_sync_gen_if.sv
// Sync/porch bus between the Color Manager line-timing source and its consumers.
// The master modport is the generator; CfgError exists only with CM_SYNC_GEN_CFG_CHECK_EN.
interface color_manager_sync_gen_if #(
    parameter int BACKPORCH_WIDTH  = 8,
    parameter int FRONTPORCH_WIDTH = 12,
    parameter int BLANK_WIDTH      = 8,
    parameter int LINE_COUNT_WIDTH = 10
);
    logic                        Enable;
    logic [BACKPORCH_WIDTH-1:0]  BackPorch;
    logic [FRONTPORCH_WIDTH-1:0] FrontPorch;
    logic [BLANK_WIDTH-1:0]      BlankLen;
    logic [LINE_COUNT_WIDTH-1:0] LinesPerFrame;
    logic                        Sync;
    logic                        Active;
    logic [FRONTPORCH_WIDTH-1:0] Position;
    logic [LINE_COUNT_WIDTH-1:0] LineNumber;
    logic                        FrameStart;
`ifdef CM_SYNC_GEN_CFG_CHECK_EN
    logic                        CfgError;
`endif

    modport master (
        input  Enable, BackPorch, FrontPorch, BlankLen, LinesPerFrame,
        output Sync, Active, Position, LineNumber, FrameStart
`ifdef CM_SYNC_GEN_CFG_CHECK_EN
        , output CfgError
`endif
    );

    modport slave (
        output Enable, BackPorch, FrontPorch, BlankLen, LinesPerFrame,
        input  Sync, Active, Position, LineNumber, FrameStart
`ifdef CM_SYNC_GEN_CFG_CHECK_EN
        , input CfgError
`endif
    );
endinterface

// File: rtl/color_manager_sync_gen.sv
// Line-timing source: Sync-high lines separated by a programmable blank, with line/frame tracking.
// Optional CM_SYNC_GEN_CFG_CHECK_EN adds CfgError, flagging lines with an empty active window.
module color_manager_sync_gen #(
    parameter int BACKPORCH_WIDTH  = 8,
    parameter int FRONTPORCH_WIDTH = 12,
    parameter int BLANK_WIDTH      = 8,
    parameter int LINE_COUNT_WIDTH = 10
) (
    input  logic                     Clk,
    input  logic                     Rst,
    color_manager_sync_gen_if.master bus
);
    localparam int CW = ((FRONTPORCH_WIDTH > BACKPORCH_WIDTH) ? FRONTPORCH_WIDTH : BACKPORCH_WIDTH) + 1;

    typedef enum logic [1:0] {IDLE, LINE, BLANK} state_t;

    state_t                      state_q, state_d;
    logic [BACKPORCH_WIDTH-1:0]  bp_q, bp_d;
    logic [FRONTPORCH_WIDTH-1:0] fp_q, fp_d;
    logic [BLANK_WIDTH-1:0]      bl_q, bl_d;
    logic [LINE_COUNT_WIDTH-1:0] lpf_q, lpf_d;
    logic [BLANK_WIDTH-1:0]      cnt_q, cnt_d;
    logic                        sync_q, sync_d;
    logic                        active_q, active_d;
    logic [FRONTPORCH_WIDTH-1:0] pos_q, pos_d;
    logic [LINE_COUNT_WIDTH-1:0] line_q, line_d;
    logic                        fs_q, fs_d;
    logic                        start_line;
    logic                        cfg_bad;

    always_comb begin
        state_d    = state_q;
        bp_d       = bp_q;
        fp_d       = fp_q;
        bl_d       = bl_q;
        lpf_d      = lpf_q;
        cnt_d      = cnt_q;
        sync_d     = sync_q;
        pos_d      = pos_q;
        line_d     = line_q;
        fs_d       = 1'b0;
        start_line = 1'b0;

        case (state_q)
            IDLE: begin
                sync_d = 1'b0;
                pos_d  = '0;
                if (bus.Enable) begin
                    state_d    = LINE;
                    start_line = 1'b1;
                    sync_d     = 1'b1;
                    line_d     = '0;
                    fs_d       = 1'b1;
                end
            end
            LINE: begin
                if (pos_q == fp_q) begin
                    state_d = BLANK;
                    sync_d  = 1'b0;
                    pos_d   = '0;
                    cnt_d   = (bl_q == '0) ? BLANK_WIDTH'(1) : bl_q;
                end else begin
                    pos_d = pos_q + FRONTPORCH_WIDTH'(1);
                end
            end
            BLANK: begin
                if (cnt_q <= BLANK_WIDTH'(1)) begin
                    if (bus.Enable) begin
                        state_d    = LINE;
                        start_line = 1'b1;
                        sync_d     = 1'b1;
                        pos_d      = '0;
                        // lpf_q - 1 is all-ones when LinesPerFrame is 0, giving the full 2^W wrap
                        line_d     = (line_q == lpf_q - LINE_COUNT_WIDTH'(1)) ? '0
                                                                              : line_q + LINE_COUNT_WIDTH'(1);
                        fs_d       = (line_d == '0);
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    cnt_d = cnt_q - BLANK_WIDTH'(1);
                end
            end
            default: begin
                state_d = IDLE;
                sync_d  = 1'b0;
                pos_d   = '0;
            end
        endcase

        if (start_line) begin
            bp_d  = bus.BackPorch;
            fp_d  = bus.FrontPorch;
            bl_d  = bus.BlankLen;
            lpf_d = bus.LinesPerFrame;
        end

        active_d = sync_d && (CW'(pos_d) > CW'(bp_d)) && (pos_d < fp_d);
        cfg_bad  = start_line && (CW'(fp_d) <= CW'(bp_d) + CW'(1));
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q  <= IDLE;
            bp_q     <= '0;
            fp_q     <= '0;
            bl_q     <= '0;
            lpf_q    <= '0;
            cnt_q    <= '0;
            sync_q   <= 1'b0;
            active_q <= 1'b0;
            pos_q    <= '0;
            line_q   <= '0;
            fs_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            bp_q     <= bp_d;
            fp_q     <= fp_d;
            bl_q     <= bl_d;
            lpf_q    <= lpf_d;
            cnt_q    <= cnt_d;
            sync_q   <= sync_d;
            active_q <= active_d;
            pos_q    <= pos_d;
            line_q   <= line_d;
            fs_q     <= fs_d;
        end
    end

`ifdef CM_SYNC_GEN_CFG_CHECK_EN
    logic cfg_err_q;

    always_ff @(posedge Clk) begin
        if (Rst) begin
            cfg_err_q <= 1'b0;
        end else begin
            cfg_err_q <= cfg_bad;
        end
    end

    assign bus.CfgError = cfg_err_q;
`else
    logic unused_cfg;
    assign unused_cfg = cfg_bad;
`endif

    assign bus.Sync       = sync_q;
    assign bus.Active     = active_q;
    assign bus.Position   = pos_q;
    assign bus.LineNumber = line_q;
    assign bus.FrameStart = fs_q;
endmodule

// File: tb/tb_color_manager_sync_gen.sv
// Directed bench for color_manager_sync_gen: expected output stream queued per step, checked every cycle.
module tb_color_manager_sync_gen;
    logic clk;
    logic rst;

    color_manager_sync_gen_if bus ();

    color_manager_sync_gen dut (
        .Clk (clk),
        .Rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic        sync;
        logic        active;
        logic [11:0] pos;
        logic [9:0]  line;
        logic        fs;
`ifdef CM_SYNC_GEN_CFG_CHECK_EN
        logic        cfg;
`endif
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d at %0t", tag, obs, expv, $time);
        end
    endtask

    // Positions 0..n-1 of a line; Active strictly inside (bp, fp)
    task automatic push_line(input int fp, input int bp, input int ln, input bit fs, input int n);
        exp_t e;
        for (int i = 0; i < n; i++) begin
            e        = '0;
            e.sync   = 1'b1;
            e.pos    = 12'(i);
            e.active = (i > bp) && (i < fp);
            e.line   = 10'(ln);
            e.fs     = fs && (i == 0);
`ifdef CM_SYNC_GEN_CFG_CHECK_EN
            e.cfg    = (i == 0) && (fp <= bp + 1);
`endif
            exp_q.push_back(e);
        end
    endtask

    // Blank and idle look identical on the outputs
    task automatic push_low(input int n, input int ln);
        exp_t e;
        for (int i = 0; i < n; i++) begin
            e      = '0;
            e.line = 10'(ln);
            exp_q.push_back(e);
        end
    endtask

    task automatic step(input int n);
        exp_t e;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            checks++;
            assert (exp_q.size() > 0) else begin
                errors++;
                $error("FAIL queue_underflow observed=0 expected=1 at %0t", $time);
            end
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("Sync",       32'(bus.Sync),       32'(e.sync));
                chk("Active",     32'(bus.Active),     32'(e.active));
                chk("Position",   32'(bus.Position),   32'(e.pos));
                chk("LineNumber", 32'(bus.LineNumber), 32'(e.line));
                chk("FrameStart", 32'(bus.FrameStart), 32'(e.fs));
`ifdef CM_SYNC_GEN_CFG_CHECK_EN
                chk("CfgError",   32'(bus.CfgError),   32'(e.cfg));
`endif
            end
        end
    endtask

    initial begin
        rst               = 1'b1;
        bus.Enable        = 1'b0;
        bus.BackPorch     = 8'd2;
        bus.FrontPorch    = 12'd6;
        bus.BlankLen      = 8'd3;
        bus.LinesPerFrame = 10'd2;

        // Reset state
        push_low(2, 0);
        step(2);
        rst = 1'b0;
        push_low(1, 0);
        step(1);

        // Basic line and frame wrap: five lines, then part of a sixth
        bus.Enable = 1'b1;
        for (int k = 0; k < 5; k++) begin
            push_line(6, 2, k % 2, (k % 2) == 0, 7);
            push_low(3, k % 2);
        end
        push_line(6, 2, 1, 1'b0, 7);
        step(50 + 3);

        // Graceful stop at Position 2: line and blank complete, then idle holding LineNumber
        bus.Enable = 1'b0;
        push_low(3, 1);
        push_low(3, 1);
        step(4 + 3 + 3);

        // Restart, then change FrontPorch at Position 4
        bus.Enable = 1'b1;
        push_line(6, 2, 0, 1'b1, 7);
        step(5);
        bus.FrontPorch = 12'd9;
        push_low(3, 0);
        push_line(9, 2, 1, 1'b0, 10);
        push_low(3, 1);
        push_line(9, 2, 0, 1'b1, 5);
        step(2 + 3 + 10 + 3 + 5);

        // Reset mid-line at Position 4 with Enable held
        rst = 1'b1;
        push_low(1, 0);
        step(1);
        rst = 1'b0;
        push_line(9, 2, 0, 1'b1, 10);
        step(1);

        // Degenerate sizes take effect from the next line
        bus.FrontPorch = 12'd0;
        bus.BlankLen   = 8'd0;
        push_low(3, 0);
        for (int k = 1; k <= 3; k++) begin
            push_line(0, 2, k % 2, (k % 2) == 0, 1);
            push_low(1, k % 2);
        end
        push_line(0, 2, 0, 1'b1, 1);
        step(9 + 3 + 6 + 1);
        bus.Enable = 1'b0;
        push_low(1, 0);
        push_low(2, 0);
        step(3);

        checks++;
        assert (exp_q.size() == 0) else begin
            errors++;
            $error("FAIL queue_leftover observed=%0d expected=0", exp_q.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/color_manager_sync_gen.md
Name: color_manager_sync_gen

Overview:
Line-timing source for the Color Manager. It is the transmit end of the Sync/porch interface that the pixel counter consumes.
- Drives Sync high for one line, then low for a programmable blanking gap.
- Provides the in-line position, an Active window flag, a line number and a frame-start pulse.
- Active uses the same strict window the counter uses, so both stay aligned: BackPorch < position < FrontPorch.

Parameters:
- BACKPORCH_WIDTH, 8, width of BackPorch.
- FRONTPORCH_WIDTH, 12, width of FrontPorch and Position.
- BLANK_WIDTH, 8, width of BlankLen.
- LINE_COUNT_WIDTH, 10, width of LinesPerFrame and LineNumber.

Ports:
- Clk  input  1  clock, all logic on the rising edge.
- Rst  input  1  synchronous reset, active-high.
- Enable  input  1  run request.
- BackPorch  input  BACKPORCH_WIDTH  last position before the active window.
- FrontPorch  input  FRONTPORCH_WIDTH  last position of a line; the line is FrontPorch+1 cycles long.
- BlankLen  input  BLANK_WIDTH  Sync-low cycles between lines; 0 is treated as 1.
- LinesPerFrame  input  LINE_COUNT_WIDTH  lines per frame; 0 is treated as 2^LINE_COUNT_WIDTH.
- Sync  output  1  high during a line.
- Active  output  1  high while BackPorch < Position < FrontPorch and Sync is high.
- Position  output  FRONTPORCH_WIDTH  cycle index within the current line; 0 while Sync is low.
- LineNumber  output  LINE_COUNT_WIDTH  index of the current or last line.
- FrameStart  output  1  one-cycle pulse at Position 0 of line 0.

Behaviour:
- All outputs are registered.
- Reset: the next Clk edge with Rst=1 sets state IDLE and drives Sync, Active, Position, LineNumber and FrameStart to 0. Reset mid-line aborts immediately.
- States: IDLE, LINE, BLANK.
- IDLE:
  - Enable=1 at an edge: go to LINE.
  - Same edge: Sync=1, Position=0, LineNumber=0, FrameStart=1.
  - Latency from the edge that samples Enable to Sync high is that same edge, so there is no idle cycle.
- Configuration latch:
  - BackPorch, FrontPorch, BlankLen and LinesPerFrame are captured into shadow registers at every entry to LINE.
  - Input changes mid-line or mid-blank take effect on the next line only.
- LINE:
  - Position increments by 1 each cycle.
  - At Position == FrontPorch (shadow value): next edge goes to BLANK, Sync=0, Position=0, blank counter loaded.
  - FrontPorch=0 gives a 1-cycle line.
- Active:
  - Computed from the next-state Position, so it is cycle-aligned with Position.
  - For FrontPorch <= BackPorch+1 there are no Active cycles, but the line still runs in full.
  - Comparison is unsigned, with BackPorch zero-extended to FRONTPORCH_WIDTH.
- BLANK:
  - Lasts max(BlankLen,1) cycles.
  - On expiry with Enable=1: go to LINE.
  - LineNumber advances by 1 and wraps to 0 after LinesPerFrame-1.
  - FrameStart pulses when LineNumber becomes 0.
  - On expiry with Enable=0: go to IDLE. LineNumber is held until the next start, which reloads it to 0.
- Enable deassert mid-line or mid-blank: the current line and its blank complete, then IDLE. A line is never truncated.
- FrameStart is high for exactly one cycle per frame.

Optional Feature:
CM_SYNC_GEN_CFG_CHECK_EN
- Defined:
  - Adds output CfgError (1 bit, reset 0).
  - CfgError pulses for one cycle, aligned with Position 0, on any line whose latched FrontPorch <= BackPorch+1 (empty active window).
- Undefined:
  - The port and its logic are absent.
  - Timing is otherwise identical.

Test Plan:
- Basic line:
  - Stimulus: BackPorch=2, FrontPorch=6, BlankLen=3, LinesPerFrame=2, Enable=1.
  - Response: Sync high for 7 cycles with Position 0..6; Active only at Position 3,4,5; Sync low for 3 cycles; period 10.
- Frame wrap:
  - Stimulus: same configuration, run 5 lines.
  - Response: LineNumber 0,1,0,1,0; FrameStart pulses every 20 cycles, the first one on the edge that samples Enable.
- Degenerate sizes:
  - Stimulus: FrontPorch=0, BlankLen=0.
  - Response: Sync alternates 1,0 every cycle; Active never asserts (with the macro defined, CfgError pulses every line).
- Graceful stop:
  - Stimulus: drop Enable at Position 2 of a line.
  - Response: the line still reaches Position 6, 3 blank cycles follow, then IDLE with Sync=0; re-asserting Enable restarts at LineNumber 0 with FrameStart.
- Config change mid-line:
  - Stimulus: change FrontPorch from 6 to 9 at Position 4.
  - Response: the current line ends at 6; the next line runs Position 0..9 with Active at 3..8.
- Reset mid-line:
  - Stimulus: Rst=1 for one edge at Position 4 with Enable held at 1.
  - Response: all outputs 0 on that edge; the next edge starts a fresh line at Position 0, LineNumber 0, FrameStart=1.
